axi4_ram_responder: RTL and testbench
=====================================

// Module: axi4_ram_responder
// PURPOSE
//  AXI4 slave (responder) terminating an AXI4 master port, e.g. the outport_* side of the AXI4 clock-domain bridge.
//  Converts AXI4 bursts into single-cycle accesses on a synchronous RAM port (1-cycle read latency).
//  Single clock domain; serves one burst at a time (no interleave, no outstanding overlap).
//  Used as the on-chip frame/sample buffer endpoint behind the CDC.
// PARAMETERS
//  RAM_AW   14  RAM word-address width; byte space = 2^(RAM_AW+2), upper AXI address bits ignored
// PORTS
//  clk_i                                     in   1      clock
//  rst_n_i                                   in   1      reset, asynchronous, active-low
//  inport_aw{valid,addr,id,len,burst}_i      in   1/32/4/8/2  AXI4 write address
//  inport_awready_o                          out  1      write address accept
//  inport_w{valid,data,strb,last}_i          in   1/32/4/1  AXI4 write data
//  inport_wready_o                           out  1      write data accept
//  inport_bready_i                           in   1      write response accept
//  inport_b{valid,resp,id}_o                 out  1/2/4  AXI4 write response
//  inport_ar{valid,addr,id,len,burst}_i      in   1/32/4/8/2  AXI4 read address
//  inport_arready_o                          out  1      read address accept
//  inport_rready_i                           in   1      read data accept
//  inport_r{valid,data,resp,id,last}_o       out  1/32/2/4/1  AXI4 read data
//  ram_addr_o   out RAM_AW  word address;  ram_wr_o out 4  byte write enables
//  ram_wdata_o  out 32  write data;  ram_rd_o out 1  read strobe;  ram_rdata_i in 32  data, valid cycle after ram_rd_o
// BEHAVIOUR
//  Reset: all *_valid/*_ready, ram_wr_o, ram_rd_o = 0; ids/resp/rdata/rlast/ram_addr/ram_wdata = 0; FSM=IDLE; priority=write.
//  Reset is async: asserting mid-burst aborts immediately; RAM sees no further strobes; read FIFO flushed.
//  Size fixed at 4 bytes/beat (awsize/arsize not ported). bresp/rresp always 2'b00 OKAY.
//  FSM IDLE -> WRITE | READ; WRITE -> WRESP; WRESP -> IDLE; READ -> IDLE.
//  IDLE: awready/arready driven combinationally for the granted channel only. Only one valid -> grant it;
//   both valid same cycle -> grant the channel not granted last (toggle bit, reset = write first).
//   On handshake latch id, addr, len, burst; beat counter = 0.
//  WRITE: wready=1. Each wvalid beat: ram_wr_o=wstrb, ram_addr_o=addr[RAM_AW+1:2], ram_wdata_o=wdata, same cycle
//   (combinational). Burst ends on beat counter==len; wlast ignored (early/late wlast not checked). 1 beat/cycle.
//  WRESP: bvalid=1, bid=latched id, held until bready; -> IDLE the cycle after handshake.
//  READ: ram_rd_o issued when (in_flight + fifo_count - pop) < 2 and beats remain; ram_rdata_i pushed to 2-entry
//   FIFO with rlast (issued beat==len) and rid. rvalid = FIFO non-empty. Sustains 1 beat/cycle with rready=1.
//   AR accepted cycle T -> first ram_rd_o T+1 -> rvalid T+3. rready low: issue stalls, no beat lost/duplicated.
//   -> IDLE the cycle after the rlast beat handshakes.
//  Address update per beat: FIXED(00) unchanged; INCR(01) +4 modulo 2^(RAM_AW+2); WRAP(10) mask=(len+1)*4-1,
//   addr=(addr&~mask)|((addr+4)&mask), legal len 1/3/7/15 only (others behave as INCR); 11 reserved -> INCR.
//  awaddr/araddr[1:0] ignored (word aligned). len=0 is a single beat.
// STRUCTURE
//  Package axi4_pkg: burst encodings (FIXED/INCR/WRAP), resp OKAY, FSM state enum, id/len widths.
//  Sub-module axi4_burst_addr_gen: combinational next-address from addr/len/burst; shared by WRITE and READ.
//  Read FIFO inline (2 entries, 37 bits: data, id, last).
// TESTING
//  AW INCR addr 0x100 len 3, W 0xA0..0xA3 strb F -> ram_wr_o at words 0x40..0x43; bvalid bid=awid resp 0.
//  AR INCR 0x100 len 3, rready=1 -> rdata 0xA0..0xA3 on consecutive cycles, rvalid at T+3, rlast on 4th only.
//  AR WRAP 0x10C len 3 -> ram_addr_o 0x43,0x40,0x41,0x42; FIXED len 2 -> 0x43 three times.
//  AW and AR valid same cycle from reset -> write granted first, read next; repeat -> read granted first.
//  Read len 7 with rready toggled 1-0-0-1 pattern -> 8 beats in order, none dropped, ram reads never >2 ahead.
//  wstrb 4'b0101 single beat -> ram_wr_o=0101; rst_n_i pulsed mid read burst -> rvalid=0 async, next AR served clean.

Source files
------------

// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings, widths and FSM state codes for the RAM responder.
// Read FIFO entries carry data, id and last together so one beat moves as one word.
package axi4_pkg;

  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_WRESP = 2'd2;
  localparam logic [1:0] ST_READ  = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
  } rd_entry_t;

endpackage

// File: rtl/axi4_ram_responder_if.sv
// AXI4 channel bundle between a master and the RAM responder.
// The responder drives the ready/response side through the slave modport.
interface axi4_ram_responder_if;
  import axi4_pkg::*;

  logic              awvalid;
  logic [31:0]       awaddr;
  logic [ID_W-1:0]   awid;
  logic [LEN_W-1:0]  awlen;
  logic [1:0]        awburst;
  logic              awready;

  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wready;

  logic              bvalid;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;
  logic              bready;

  logic              arvalid;
  logic [31:0]       araddr;
  logic [ID_W-1:0]   arid;
  logic [LEN_W-1:0]  arlen;
  logic [1:0]        arburst;
  logic              arready;

  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              rlast;
  logic              rready;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arburst,
    output arready,
    output rvalid, rdata, rresp, rid, rlast,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rid, rlast,
    output rready
  );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
// WRAP with a length other than 2/4/8/16 beats, and the reserved code, step like INCR.
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [AW-1:0]    addr,
  input  logic [LEN_W-1:0] len,
  input  logic [1:0]       burst,
  output logic [AW-1:0]    next_addr
);

  logic [AW-1:0] incr_addr;
  logic [AW-1:0] wrap_mask;
  logic          wrap_ok;

  always_comb begin
    incr_addr = addr + AW'(4);
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    // (len+1)*4-1 for the legal wrap lengths is just len with two ones appended
    wrap_mask = AW'({len[3:0], 2'b11});
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~wrap_mask) | (incr_addr & wrap_mask))
                                       : incr_addr;
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi4_ram_responder.sv
// AXI4 slave that turns one burst at a time into single-cycle accesses on a
// synchronous RAM (1-cycle read latency) with a 2-entry read return FIFO.
//
// state    | meaning
// ST_IDLE  | arbitrate AW/AR, latch burst on handshake
// ST_WRITE | one W beat per cycle straight to the RAM write port
// ST_WRESP | hold B response until bready
// ST_READ  | issue RAM reads, return beats through the FIFO until rlast pops
module axi4_ram_responder
  import axi4_pkg::*;
#(
  parameter int RAM_AW = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  axi4_ram_responder_if.slave    bus,
  output logic [RAM_AW-1:0]      ram_addr_o,
  output logic [STRB_W-1:0]      ram_wr_o,
  output logic [DATA_W-1:0]      ram_wdata_o,
  output logic                   ram_rd_o,
  input  logic [DATA_W-1:0]      ram_rdata_i
);

  localparam int BAW = RAM_AW + 2;

  logic [1:0]       state_q;
  logic             prio_wr_q;
  logic [ID_W-1:0]  id_q;
  logic [BAW-1:0]   addr_q;
  logic [BAW-1:0]   addr_next;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       burst_q;
  logic [LEN_W:0]   beat_q;
  logic             in_flight_q;
  logic             in_flight_last_q;
  rd_entry_t        fifo_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  logic             is_idle;
  logic             contend;
  logic             grant_wr;
  logic             grant_rd;
  logic             aw_hs;
  logic             ar_hs;
  logic             w_beat;
  logic             at_last_beat;
  logic             b_hs;
  logic             beats_left;
  logic             rd_issue;
  logic             push;
  logic             pop;
  logic [1:0]       occupancy;
  rd_entry_t        head;

  // Arbitration: a lone request wins; on contention the toggle bit decides.
  assign is_idle     = (state_q == ST_IDLE);
  assign contend     = bus.awvalid && bus.arvalid;
  assign grant_wr    = bus.awvalid && (!bus.arvalid || prio_wr_q);
  assign grant_rd    = bus.arvalid && (!bus.awvalid || !prio_wr_q);
  assign bus.awready = is_idle && grant_wr;
  assign bus.arready = is_idle && grant_rd;
  assign aw_hs       = bus.awvalid && bus.awready;
  assign ar_hs       = bus.arvalid && bus.arready;

  assign at_last_beat = (beat_q == {1'b0, len_q});
  assign bus.wready   = (state_q == ST_WRITE);
  assign w_beat       = bus.wready && bus.wvalid;

  assign bus.bvalid = (state_q == ST_WRESP);
  assign bus.bresp  = RESP_OKAY;
  assign bus.bid    = id_q;
  assign b_hs       = bus.bvalid && bus.bready;

  assign head       = fifo_q[rd_ptr_q];
  assign bus.rvalid = (count_q != 2'd0);
  assign pop        = bus.rvalid && bus.rready;
  assign push       = in_flight_q;

  // Reads in flight plus buffered beats may never exceed the FIFO depth.
  assign occupancy  = {1'b0, in_flight_q} + count_q - {1'b0, pop};
  assign beats_left = (beat_q <= {1'b0, len_q});
  assign rd_issue   = (state_q == ST_READ) && beats_left && (occupancy < 2'd2);

  assign bus.rdata = bus.rvalid ? head.data : '0;
  assign bus.rid   = bus.rvalid ? head.id   : '0;
  assign bus.rlast = bus.rvalid ? head.last : 1'b0;
  assign bus.rresp = RESP_OKAY;

  assign ram_addr_o  = addr_q[BAW-1:2];
  assign ram_wr_o    = w_beat ? bus.wstrb : '0;
  assign ram_wdata_o = w_beat ? bus.wdata : '0;
  assign ram_rd_o    = rd_issue;

  logic unused_bits;
  assign unused_bits = ^{bus.wlast, bus.awaddr[31:BAW], bus.awaddr[1:0],
                         bus.araddr[31:BAW], bus.araddr[1:0]};

  axi4_burst_addr_gen #(
    .AW (BAW)
  ) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (addr_next)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q          <= ST_IDLE;
      prio_wr_q        <= 1'b1;
      id_q             <= '0;
      addr_q           <= '0;
      len_q            <= '0;
      burst_q          <= BURST_INCR;
      beat_q           <= '0;
      in_flight_q      <= 1'b0;
      in_flight_last_q <= 1'b0;
    end else begin
      in_flight_q <= rd_issue;
      if (rd_issue) begin
        in_flight_last_q <= at_last_beat;
      end
      case (state_q)
        ST_IDLE: begin
          if (contend) begin
            prio_wr_q <= ~prio_wr_q;
          end
          if (aw_hs) begin
            id_q    <= bus.awid;
            addr_q  <= {bus.awaddr[BAW-1:2], 2'b00};
            len_q   <= bus.awlen;
            burst_q <= bus.awburst;
            beat_q  <= '0;
            state_q <= ST_WRITE;
          end else if (ar_hs) begin
            id_q    <= bus.arid;
            addr_q  <= {bus.araddr[BAW-1:2], 2'b00};
            len_q   <= bus.arlen;
            burst_q <= bus.arburst;
            beat_q  <= '0;
            state_q <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (w_beat) begin
            addr_q <= addr_next;
            beat_q <= beat_q + 1'b1;
            if (at_last_beat) begin
              state_q <= ST_WRESP;
            end
          end
        end
        ST_WRESP: begin
          if (b_hs) begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (rd_issue) begin
            addr_q <= addr_next;
            beat_q <= beat_q + 1'b1;
          end
          if (pop && head.last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // RAM data arrives the cycle after the strobe; capture it with its tag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{data: ram_rdata_i, id: id_q, last: in_flight_last_q};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_ram_responder.sv
// Randomised bench for axi4_ram_responder: a shadow memory and burst address
// arithmetic predict every RAM access and every returned read beat.
module tb_axi4_ram_responder;
  import axi4_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [13:0] ram_addr_o;
  logic [3:0]  ram_wr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_rd_o;
  logic [31:0] ram_rdata_i = '0;

  axi4_ram_responder_if bus();

  axi4_ram_responder #(.RAM_AW(14)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .bus         (bus.slave),
    .ram_addr_o  (ram_addr_o),
    .ram_wr_o    (ram_wr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rd_o    (ram_rd_o),
    .ram_rdata_i (ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous RAM seen by the DUT
  logic [31:0] ram_mem [0:16383];
  always @(posedge clk_i) begin
    if (ram_rd_o) ram_rdata_i <= ram_mem[ram_addr_o];
    for (int b = 0; b < 4; b++)
      if (ram_wr_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_wdata_o[8*b +: 8];
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { int w; logic [31:0] d; logic [3:0] s; } wr_t;
  wr_t         wr_q [$];
  logic [13:0] rd_q [$];
  int          rd_n, pop_n, max_ahead;
  logic [31:0] ref_mem [int];

  always @(negedge clk_i) begin
    if (ram_wr_o != 4'h0) wr_q.push_back('{int'(ram_addr_o), ram_wdata_o, ram_wr_o});
    if (ram_rd_o) begin rd_q.push_back(ram_addr_o); rd_n++; end
    if (bus.rvalid && bus.rready) pop_n++;
    if (rd_n - pop_n > max_ahead) max_ahead = rd_n - pop_n;
  end

  function automatic int ref_next(int a, int len, int burst);
    int sz;
    if (burst == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      sz = (len + 1) * 4;
      return (a / sz) * sz + ((a + 4) % sz);
    end
    return (a + 4) % 65536;
  endfunction

  function automatic logic [31:0] ref_rd(int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  function automatic int byte_addr(logic [31:0] addr);
    return int'(addr % 32'd65536) / 4 * 4;
  endfunction

  task automatic idle_inputs();
    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awburst = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arburst = 0;
    bus.rready = 0;
  endtask

  task automatic apply_reset();
    rst_n_i = 0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1;
  endtask

  task automatic wait_rdy(input int which, input string nm);
    bit ok = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk_i);
      if ((which == 0 && bus.awready) || (which == 1 && bus.arready) ||
          (which == 2 && bus.wready) || (which == 3 && bus.bvalid) ||
          (which == 4 && bus.rvalid)) begin ok = 1; break; end
      @(posedge clk_i); #1;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL %s: timeout got=0 exp=1", nm); end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [3:0] strb, input logic [31:0] d0);
    int a;
    logic [31:0] m;
    wr_q.delete();
    @(posedge clk_i); #1;
    bus.awvalid = 1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len); bus.awburst = burst;
    wait_rdy(0, "aw_accept");
    @(posedge clk_i); #1;
    bus.awvalid = 0;
    for (int k = 0; k <= len; k++) begin
      bus.wvalid = 1; bus.wdata = d0 + k; bus.wstrb = strb; bus.wlast = (k == len);
      wait_rdy(2, "w_accept");
      @(posedge clk_i); #1;
    end
    bus.wvalid = 0; bus.wlast = 0; bus.bready = 1;
    wait_rdy(3, "b_valid");
    total++;
    if (bus.bid !== id || bus.bresp !== 2'b00) begin
      bad++; $display("FAIL b_resp: bid=%0h bresp=%0d exp bid=%0h bresp=0", bus.bid, bus.bresp, id);
    end
    @(posedge clk_i); #1;
    bus.bready = 0;
    total++;
    if (wr_q.size() != len + 1) begin
      bad++; $display("FAIL wr_count: got=%0d exp=%0d", wr_q.size(), len + 1);
    end
    a = byte_addr(addr);
    for (int k = 0; k <= len; k++) begin
      if (k < wr_q.size()) begin
        total++;
        if (wr_q[k].w !== a / 4 || wr_q[k].d !== d0 + k || wr_q[k].s !== strb) begin
          bad++;
          $display("FAIL wr_beat%0d: got w=%0h d=%0h s=%0h exp w=%0h d=%0h s=%0h",
                   k, wr_q[k].w, wr_q[k].d, wr_q[k].s, a / 4, d0 + k, strb);
        end
      end
      m = ref_rd(a / 4);
      for (int b = 0; b < 4; b++) if (strb[b]) m[8*b +: 8] = (d0 + k) >> (8 * b);
      ref_mem[a / 4] = m;
      a = ref_next(a, len, burst);
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input bit pattern, input bit check_timing);
    int a, t_hs, first_cyc, last_cyc, k;
    bit ok;
    logic [3:0] pat = 4'b1001;
    logic [31:0] got_d [$];
    logic [3:0]  got_id [$];
    logic        got_last [$];
    logic [1:0]  got_resp [$];
    rd_q.delete(); rd_n = 0; pop_n = 0; max_ahead = 0;
    @(posedge clk_i); #1;
    bus.arvalid = 1; bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len); bus.arburst = burst;
    wait_rdy(1, "ar_accept");
    t_hs = cyc; first_cyc = -1; last_cyc = -1; k = 0; ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk_i); #1;
      bus.arvalid = 0;
      bus.rready = pattern ? pat[k % 4] : 1'b1;
      k++;
      @(negedge clk_i);
      if (bus.rvalid && first_cyc < 0) first_cyc = cyc;
      if (bus.rvalid && bus.rready) begin
        got_d.push_back(bus.rdata); got_id.push_back(bus.rid);
        got_last.push_back(bus.rlast); got_resp.push_back(bus.rresp);
        last_cyc = cyc;
        if (bus.rlast || got_d.size() > len + 4) begin ok = 1; break; end
      end
    end
    @(posedge clk_i); #1;
    bus.rready = 0;
    total++;
    if (!ok) begin bad++; $display("FAIL r_done: timeout beats=%0d exp=%0d", got_d.size(), len + 1); end
    total++;
    if (got_d.size() != len + 1) begin
      bad++; $display("FAIL r_count: got=%0d exp=%0d", got_d.size(), len + 1);
    end
    total++;
    if (rd_q.size() != len + 1) begin
      bad++; $display("FAIL ram_rd_count: got=%0d exp=%0d", rd_q.size(), len + 1);
    end
    a = byte_addr(addr);
    for (int j = 0; j <= len; j++) begin
      if (j < got_d.size()) begin
        total++;
        if ({got_d[j], got_id[j], got_last[j], got_resp[j]} !== {ref_rd(a / 4), id, (j == len), 2'b00}) begin
          bad++;
          $display("FAIL r_beat%0d: got d=%0h id=%0h last=%0b resp=%0d exp d=%0h id=%0h last=%0b resp=0",
                   j, got_d[j], got_id[j], got_last[j], got_resp[j], ref_rd(a / 4), id, (j == len));
        end
      end
      if (j < rd_q.size()) begin
        total++;
        if (int'(rd_q[j]) !== a / 4) begin
          bad++; $display("FAIL ram_rd_addr%0d: got=%0h exp=%0h", j, rd_q[j], a / 4);
        end
      end
      a = ref_next(a, len, burst);
    end
    total++;
    if (max_ahead > 2) begin bad++; $display("FAIL rd_ahead: got=%0d exp<=2", max_ahead); end
    if (check_timing) begin
      total++;
      if (first_cyc != t_hs + 3) begin
        bad++; $display("FAIL r_latency: got=%0d exp=%0d", first_cyc - t_hs, 3);
      end
      total++;
      if (last_cyc - first_cyc != len) begin
        bad++; $display("FAIL r_throughput: got=%0d exp=%0d", last_cyc - first_cyc, len);
      end
    end
  endtask

  task automatic test_reset();
    rst_n_i = 0;
    idle_inputs();
    @(negedge clk_i);
    total++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, ram_rd_o, ram_wr_o, bus.bid,
         bus.rid, bus.rlast, bus.rdata, bus.bresp, bus.rresp, ram_addr_o, ram_wdata_o} !== '0) begin
      bad++; $display("FAIL reset_in: outputs not all zero during reset");
    end
    @(posedge clk_i); #1 rst_n_i = 1;
    @(negedge clk_i);
    total++;
    if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, ram_rd_o, ram_wr_o,
         bus.rdata, ram_addr_o} !== '0) begin
      bad++; $display("FAIL reset_out: outputs not all zero after reset");
    end
  endtask

  task automatic finish_w(input logic [31:0] dw);
    @(posedge clk_i); #1;
    bus.awvalid = 0;
    bus.wvalid = 1; bus.wdata = dw; bus.wstrb = 4'hF; bus.wlast = 1;
    wait_rdy(2, "arb_w_accept");
    @(posedge clk_i); #1;
    bus.wvalid = 0; bus.wlast = 0; bus.bready = 1;
    wait_rdy(3, "arb_b_valid");
    total++;
    if (bus.bid !== 4'h1) begin bad++; $display("FAIL arb_bid: got=%0h exp=1", bus.bid); end
    ref_mem[12'h0C0] = dw;
    @(posedge clk_i); #1;
    bus.bready = 0;
  endtask

  task automatic finish_r();
    @(posedge clk_i); #1;
    bus.arvalid = 0; bus.rready = 1;
    wait_rdy(4, "arb_r_valid");
    total++;
    if ({bus.rdata, bus.rid, bus.rlast} !== {ref_rd(12'h0C0), 4'h2, 1'b1}) begin
      bad++; $display("FAIL arb_rdata: got d=%0h id=%0h last=%0b exp d=%0h id=2 last=1",
                      bus.rdata, bus.rid, bus.rlast, ref_rd(12'h0C0));
    end
    @(posedge clk_i); #1;
    bus.rready = 0;
  endtask

  task automatic test_arbitration();
    bit pw;
    apply_reset();
    pw = 1'b1;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk_i); #1;
      bus.awvalid = 1; bus.awid = 4'h1; bus.awaddr = 32'h300; bus.awlen = 0; bus.awburst = BURST_INCR;
      bus.arvalid = 1; bus.arid = 4'h2; bus.araddr = 32'h300; bus.arlen = 0; bus.arburst = BURST_INCR;
      @(negedge clk_i);
      total++;
      if ({bus.awready, bus.arready} !== {pw, !pw}) begin
        bad++; $display("FAIL arb_grant%0d: got aw=%0b ar=%0b exp aw=%0b ar=%0b",
                        r, bus.awready, bus.arready, pw, !pw);
      end
      if (pw) begin
        finish_w($urandom); wait_rdy(1, "arb_ar_after"); finish_r();
      end else begin
        finish_r(); wait_rdy(0, "arb_aw_after"); finish_w($urandom);
      end
      pw = !pw;
    end
  endtask

  task automatic test_wrap_fixed();
    do_read(4'h3, 32'h10C, 3, BURST_WRAP, 0, 0);
    total++;
    if (rd_q.size() != 4 || rd_q[0] !== 14'h43 || rd_q[1] !== 14'h40 ||
        rd_q[2] !== 14'h41 || rd_q[3] !== 14'h42) begin
      bad++; $display("FAIL wrap_addrs: got n=%0d first=%0h exp 43,40,41,42", rd_q.size(), rd_q[0]);
    end
    do_read(4'h4, 32'h10C, 2, BURST_FIXED, 0, 0);
    total++;
    if (rd_q.size() != 3 || rd_q[0] !== 14'h43 || rd_q[1] !== 14'h43 || rd_q[2] !== 14'h43) begin
      bad++; $display("FAIL fixed_addrs: got n=%0d first=%0h exp 43 x3", rd_q.size(), rd_q[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats = 0;
    do_write(4'h3, 32'h400, 7, BURST_INCR, 4'hF, $urandom);
    @(posedge clk_i); #1;
    bus.arvalid = 1; bus.arid = 4'h6; bus.araddr = 32'h400; bus.arlen = 7; bus.arburst = BURST_INCR;
    bus.rready = 1;
    wait_rdy(1, "mid_ar_accept");
    @(posedge clk_i); #1;
    bus.arvalid = 0;
    for (int t = 0; t < 20 && beats < 2; t++) begin
      @(negedge clk_i);
      if (bus.rvalid && bus.rready) beats++;
      @(posedge clk_i); #1;
    end
    total++;
    if (beats < 2) begin bad++; $display("FAIL mid_beats: got=%0d exp=2", beats); end
    #1 rst_n_i = 0;
    #1;
    total++;
    if ({bus.rvalid, ram_rd_o, ram_wr_o} !== '0) begin
      bad++; $display("FAIL mid_reset: got rvalid=%0b rd=%0b wr=%0h exp 0", bus.rvalid, ram_rd_o, ram_wr_o);
    end
    bus.rready = 0;
    @(posedge clk_i); #1 rst_n_i = 1;
    do_read(4'h7, 32'h400, 7, BURST_INCR, 0, 1);
  endtask

  task automatic test_random();
    int lens [6] = '{0, 1, 2, 3, 7, 15};
    logic [31:0] addr;
    logic [3:0] id;
    logic [1:0] burst;
    int len;
    for (int i = 0; i < 8; i++) begin
      addr  = $urandom;
      id    = 4'($urandom_range(0, 15));
      burst = 2'($urandom_range(0, 3));
      len   = lens[$urandom_range(0, 5)];
      do_write(id, addr, len, burst, 4'($urandom_range(1, 15)), $urandom);
      do_read(~id, addr, len, burst, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram_mem[i] = 32'h0;
    idle_inputs();
    test_reset();
    test_arbitration();
    do_write(4'h5, 32'h100, 3, BURST_INCR, 4'hF, 32'hA0);
    do_read(4'h9, 32'h100, 3, BURST_INCR, 0, 1);
    test_wrap_fixed();
    do_write(4'h2, 32'h800, 7, BURST_INCR, 4'hF, $urandom);
    do_read(4'hA, 32'h800, 7, BURST_INCR, 1, 0);
    do_write(4'h1, 32'h200, 0, BURST_INCR, 4'hF, 32'hFFFF_FFFF);
    do_write(4'h1, 32'h200, 0, BURST_INCR, 4'b0101, 32'h1234_5678);
    do_read(4'h1, 32'h200, 0, BURST_INCR, 0, 1);
    do_write(4'hC, 32'h1234_FFF8, 3, BURST_INCR, 4'hF, $urandom);
    do_read(4'hD, 32'h0000_FFF8, 3, BURST_INCR, 0, 1);
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
